// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the write-back stage and register file.
// Widths, register count and the hard-wired zero register index.
package pipeline_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_mux.sv
// Write-back select: chooses load data or ALU result.
// The chosen value is both committed and forwarded.
module wb_mux
    import pipeline_pkg::*;
(
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic              mem_to_reg_i,
    output logic [DATA_W-1:0] wb_data_o
);

    // 2:1 select, combinational in every cycle
    always_comb begin
        wb_data_o = alu_result_i;
        if (mem_to_reg_i) begin
            wb_data_o = read_data_i;
        end
    end

endmodule

// File: rtl/wb_reg_file.sv
// Write-back stage and 32-entry architectural register file.
// Define WB_BYPASS_EN for same-cycle write-to-read bypass.
module wb_reg_file
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inALUResult,
    input  logic [DATA_W-1:0] inReadData,
    input  logic [ADDR_W-1:0] inWriteReg,
    input  logic              inMemToReg,
    input  logic              inRegWrite,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [DATA_W-1:0] outWBData,
    output logic              outWBValid
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;

    wb_mux u_wb_mux (
        .alu_result_i (inALUResult),
        .read_data_i  (inReadData),
        .mem_to_reg_i (inMemToReg),
        .wb_data_o    (wb_data)
    );

    // A commit happens only out of reset and never to r0
    always_comb begin
        wb_valid = rst && inRegWrite && (inWriteReg != REG_ZERO);
    end

    assign outWBData  = wb_data;
    assign outWBValid = wb_valid;

    // Next array contents: only the addressed entry changes
    always_comb begin
        regs_d = regs_q;
        if (wb_valid) begin
            regs_d[inWriteReg] = wb_data;
        end
    end

    // Array state; reset clears every entry without a clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1 with optional bypass and r0 masking
    always_comb begin
        readData1 = regs_q[readReg1];
`ifdef WB_BYPASS_EN
        if (wb_valid && (readReg1 == inWriteReg)) begin
            readData1 = wb_data;
        end
`endif
        if (readReg1 == REG_ZERO) begin
            readData1 = '0;
        end
    end

    // Read port 2 with optional bypass and r0 masking
    always_comb begin
        readData2 = regs_q[readReg2];
`ifdef WB_BYPASS_EN
        if (wb_valid && (readReg2 == inWriteReg)) begin
            readData2 = wb_data;
        end
`endif
        if (readReg2 == REG_ZERO) begin
            readData2 = '0;
        end
    end

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file against an array model.
// Honours WB_BYPASS_EN the same way as the design build.
module tb_wb_reg_file;

    logic        clk;
    logic        rst;
    logic [31:0] inALUResult;
    logic [31:0] inReadData;
    logic [4:0]  inWriteReg;
    logic        inMemToReg;
    logic        inRegWrite;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] outWBData;
    logic        outWBValid;

    int n_checks;
    int n_fail;

    logic [31:0] model [32];

    wb_reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .inALUResult (inALUResult),
        .inReadData  (inReadData),
        .inWriteReg  (inWriteReg),
        .inMemToReg  (inMemToReg),
        .inRegWrite  (inRegWrite),
        .readReg1    (readReg1),
        .readReg2    (readReg2),
        .readData1   (readData1),
        .readData2   (readData2),
        .outWBData   (outWBData),
        .outWBValid  (outWBValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic logic [31:0] sel_wb();
        return inMemToReg ? inReadData : inALUResult;
    endfunction

    function automatic logic wr_active();
        return (rst === 1'b1) && (inRegWrite === 1'b1) && (inWriteReg != 5'd0);
    endfunction

    // Expected read value before the edge, from model + bypass rule
    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (BYPASS && wr_active() && idx == inWriteReg) return sel_wb();
        return model[idx];
    endfunction

    task automatic set_in(input logic we, input logic [4:0] wr,
                          input logic [31:0] alu, input logic [31:0] ld,
                          input logic mtr);
        inRegWrite  = we;
        inWriteReg  = wr;
        inALUResult = alu;
        inReadData  = ld;
        inMemToReg  = mtr;
    endtask

    // One clock edge; model commits what the spec says should commit
    task automatic step();
        logic        w;
        logic [4:0]  r;
        logic [31:0] d;
        w = wr_active();
        r = inWriteReg;
        d = sel_wb();
        @(posedge clk);
        if (w) model[r] = d;
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        set_in(1'b1, 5'd5, 32'h5555_0005, 32'h0, 1'b0);
        step();
        set_in(1'b1, 5'd9, 32'h0, 32'h9999_0009, 1'b1);
        step();
        idle();
        readReg1 = 5'd5;
        readReg2 = 5'd9;
        #1;
        if (readData1 !== 32'h5555_0005) begin
            $display("FAIL pre_reset_r5 got %h want %h", readData1, 32'h5555_0005);
            n_fail++;
        end
        n_checks++;
        set_in(1'b1, 5'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        if (readData1 !== 32'h0) begin
            $display("FAIL reset_r5 got %h want 0", readData1);
            n_fail++;
        end
        n_checks++;
        if (readData2 !== 32'h0) begin
            $display("FAIL reset_r9 got %h want 0", readData2);
            n_fail++;
        end
        n_checks++;
        if (outWBValid !== 1'b0) begin
            $display("FAIL reset_wbvalid got %b want 0", outWBValid);
            n_fail++;
        end
        n_checks++;
        @(posedge clk);
        #1;
        if (readData1 !== 32'h0) begin
            $display("FAIL reset_write_ignored got %h want 0", readData1);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        rst = 1'b1;
        idle();
        #1;
    endtask

    task automatic test_alu_write();
        set_in(1'b1, 5'b10101, 32'hA5A5_A5A5, 32'h0, 1'b0);
        readReg1 = 5'd21;
        #1;
        if (outWBValid !== 1'b1) begin
            $display("FAIL alu_wbvalid got %b want 1", outWBValid);
            n_fail++;
        end
        n_checks++;
        step();
        idle();
        #1;
        if (readData1 !== 32'hA5A5_A5A5) begin
            $display("FAIL alu_write got %h want a5a5a5a5", readData1);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_load_write();
        set_in(1'b1, 5'b01010, 32'h1357_9BDF, 32'h5A5A_5A5A, 1'b1);
        readReg2 = 5'd10;
        #1;
        if (outWBData !== 32'h5A5A_5A5A) begin
            $display("FAIL load_wbdata got %h want 5a5a5a5a", outWBData);
            n_fail++;
        end
        n_checks++;
        step();
        idle();
        #1;
        if (readData2 !== 32'h5A5A_5A5A) begin
            $display("FAIL load_write got %h want 5a5a5a5a", readData2);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_zero_reg();
        set_in(1'b1, 5'd0, 32'h1234_5678, 32'h0, 1'b0);
        readReg1 = 5'd0;
        readReg2 = 5'd0;
        #1;
        if (outWBValid !== 1'b0) begin
            $display("FAIL zero_wbvalid got %b want 0", outWBValid);
            n_fail++;
        end
        n_checks++;
        if (outWBData !== 32'h1234_5678) begin
            $display("FAIL zero_wbdata got %h want 12345678", outWBData);
            n_fail++;
        end
        n_checks++;
        step();
        idle();
        #1;
        if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
            $display("FAIL zero_read got %h/%h want 0", readData1, readData2);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        set_in(1'b1, 5'd3, 32'h1111_1111, 32'h0, 1'b0);
        step();
        set_in(1'b1, 5'd3, 32'h8765_4321, 32'h0, 1'b0);
        readReg1 = 5'd3;
        readReg2 = 5'd3;
        #1;
        want = BYPASS ? 32'h8765_4321 : 32'h1111_1111;
        if (readData1 !== want) begin
            $display("FAIL bypass_pre_edge got %h want %h", readData1, want);
            n_fail++;
        end
        n_checks++;
        if (readData2 !== readData1) begin
            $display("FAIL same_index_ports got %h want %h", readData2, readData1);
            n_fail++;
        end
        n_checks++;
        step();
        idle();
        #1;
        if (readData1 !== 32'h8765_4321) begin
            $display("FAIL bypass_post_edge got %h want 87654321", readData1);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_no_write();
        set_in(1'b0, 5'd3, 32'hDEAD_BEEF, 32'hxxxx_xxxx, 1'b1);
        readReg1 = 5'd3;
        #1;
        if (outWBValid !== 1'b0) begin
            $display("FAIL nowrite_wbvalid got %b want 0", outWBValid);
            n_fail++;
        end
        n_checks++;
        step();
        set_in(1'b0, 5'd3, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'bx);
        step();
        idle();
        #1;
        if (readData1 !== 32'h8765_4321) begin
            $display("FAIL nowrite_r3 got %h want 87654321", readData1);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_random();
        logic        we;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        mtr;
        for (int n = 0; n < 300; n++) begin
            we  = ($urandom_range(0, 3) != 0);
            wr  = 5'($urandom_range(0, 31));
            alu = $urandom;
            ld  = $urandom;
            mtr = 1'($urandom_range(0, 1));
            set_in(we, wr, alu, ld, mtr);
            readReg1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            readReg2 = ($urandom_range(0, 3) == 0) ? readReg1 : 5'($urandom_range(0, 31));
            #1;
            if (outWBData !== (mtr ? ld : alu)) begin
                $display("FAIL rnd_wbdata got %h want %h", outWBData, mtr ? ld : alu);
                n_fail++;
            end
            n_checks++;
            if (outWBValid !== (we && wr != 5'd0)) begin
                $display("FAIL rnd_wbvalid got %b want %b", outWBValid, we && wr != 5'd0);
                n_fail++;
            end
            n_checks++;
            if (readData1 !== exp_read(readReg1)) begin
                $display("FAIL rnd_rd1 r%0d got %h want %h", readReg1, readData1, exp_read(readReg1));
                n_fail++;
            end
            n_checks++;
            if (readData2 !== exp_read(readReg2)) begin
                $display("FAIL rnd_rd2 r%0d got %h want %h", readReg2, readData2, exp_read(readReg2));
                n_fail++;
            end
            n_checks++;
            step();
        end
        idle();
        #1;
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i);
            #1;
            if (readData1 !== exp_read(5'(i))) begin
                $display("FAIL rnd_scan r%0d got %h want %h", i, readData1, exp_read(5'(i)));
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_reset_midop();
        set_in(1'b1, 5'd7, 32'hCAFE_F00D, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        idle();
        #1;
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i);
            readReg2 = 5'(31 - i);
            #1;
            if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
                $display("FAIL midop_reset r%0d got %h/%h want 0", i, readData1, readData2);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst      = 1'b1;
        readReg1 = 5'd0;
        readReg2 = 5'd0;
        idle();
        #1 rst = 1'b0;
        #13;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_alu_write();
        test_load_write();
        test_zero_reg();
        test_bypass();
        test_no_write();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
